// File: rtl/rk2040_pkg.sv
// Shared definitions for the RK2040 interrupt front-end: default sizes and
// the request/service state encoding.
package rk2040_pkg;

    localparam int IRQ_WIDTH       = 24;
    localparam int IRQ_VEC_W       = 5;
    localparam int IRQ_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_REQ     = 2'd1,
        IRQ_SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/rk2040_irq_ctrl_if.sv
// Request/acknowledge/done handshake between the interrupt front-end
// (master) and the RK2040 core (slave).
interface rk2040_irq_ctrl_if #(
    parameter int VEC_W = rk2040_pkg::IRQ_VEC_W
);

    logic             irq_req;
    logic [VEC_W-1:0] irq_vector;
    logic             in_service;
    logic             irq_ack;
    logic             irq_done;

    modport master (
        output irq_req,
        output irq_vector,
        output in_service,
        input  irq_ack,
        input  irq_done
    );

    modport slave (
        input  irq_req,
        input  irq_vector,
        input  in_service,
        output irq_ack,
        output irq_done
    );

endinterface

// File: rtl/rk2040_edge_sync.sv
// Per-line synchroniser and rising/falling edge detector with a post-reset
// warm-up window that hides edges against the cleared synchroniser state.
module rk2040_edge_sync
    import rk2040_pkg::*;
#(
    parameter int WIDTH       = IRQ_WIDTH,
    parameter int SYNC_STAGES = IRQ_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] edge_sel,
    output logic [WIDTH-1:0] edge_o
);

    localparam int WARM  = SYNC_STAGES + 1;
    localparam int CNT_W = $clog2(WARM + 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [CNT_W-1:0] warm_q, warm_d;
    logic             warm_done;
    logic [WIDTH-1:0] s, rise, fall;

    always_comb begin
        sync_d[0] = din;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
        s         = sync_q[SYNC_STAGES-1];
        prev_d    = s;
        warm_done = (warm_q == CNT_W'(WARM));
        warm_d    = warm_done ? warm_q : warm_q + 1'b1;
        rise      = ~prev_q & s;
        fall      = prev_q & ~s;
        // edge_sel = 1 picks the falling edge for that line
        edge_o    = warm_done ? ((edge_sel & fall) | (~edge_sel & rise)) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            prev_q <= '0;
            warm_q <= '0;
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            prev_q <= prev_d;
            warm_q <= warm_d;
        end
    end

endmodule

// File: rtl/rk2040_irq_ctrl.sv
// Interrupt front-end: latches enabled edges as pending, picks the lowest
// enabled pending line and runs a non-nesting req/ack/done handshake.
module rk2040_irq_ctrl
    import rk2040_pkg::*;
#(
    parameter int WIDTH       = IRQ_WIDTH,
    parameter int SYNC_STAGES = IRQ_SYNC_STAGES,
    parameter int VEC_W       = IRQ_VEC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  inputPort,
    input  logic [WIDTH-1:0]  irq_en,
    input  logic [WIDTH-1:0]  irq_edge_sel,
    output logic [WIDTH-1:0]  irq_pending,
    rk2040_irq_ctrl_if.master irq_bus
);

    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [WIDTH-1:0] active;
    logic [VEC_W-1:0] win;
    logic [VEC_W-1:0] vec_q;
    logic             req_q;
    logic             svc_q;
    irq_state_e       state_q;

    rk2040_edge_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk      (clk),
        .rst      (rst),
        .din      (inputPort),
        .edge_sel (irq_edge_sel),
        .edge_o   (edge_pulse)
    );

    // Fixed priority: the lowest enabled pending index wins.
    always_comb begin
        active = pending_q & irq_en;
        win    = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (active[i]) begin
                win = VEC_W'(i);
            end
        end
    end

    // A fresh edge on the line being acknowledged survives the clear.
    always_comb begin
        pending_d = pending_q;
        if (state_q == IRQ_REQ && irq_bus.irq_ack) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (vec_q == VEC_W'(i)) begin
                    pending_d[i] = 1'b0;
                end
            end
        end
        pending_d = pending_d | (edge_pulse & irq_en);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IRQ_IDLE;
            req_q   <= 1'b0;
            vec_q   <= '0;
            svc_q   <= 1'b0;
        end else begin
            case (state_q)
                IRQ_IDLE: begin
                    if (|active) begin
                        vec_q   <= win;
                        req_q   <= 1'b1;
                        state_q <= IRQ_REQ;
                    end
                end
                IRQ_REQ: begin
                    if (irq_bus.irq_ack) begin
                        req_q   <= 1'b0;
                        svc_q   <= 1'b1;
                        state_q <= IRQ_SERVICE;
                    end
                end
                IRQ_SERVICE: begin
                    if (irq_bus.irq_done) begin
                        svc_q   <= 1'b0;
                        state_q <= IRQ_IDLE;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    svc_q   <= 1'b0;
                    state_q <= IRQ_IDLE;
                end
            endcase
        end
    end

    assign irq_pending        = pending_q;
    assign irq_bus.irq_req    = req_q;
    assign irq_bus.irq_vector = vec_q;
    assign irq_bus.in_service = svc_q;

endmodule
